// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle around the two-master / one-slave memory arbiter.
// master: the core and memory side that drives requests; slave: the arbiter.
interface mem_bus_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          m0_req;
    logic [AW-1:0] m0_addr;
    logic          m0_we;
    logic [DW-1:0] m0_wdata;
    logic          m0_gnt;
    logic          m0_rvalid;
    logic [DW-1:0] m0_rdata;

    logic          m1_req;
    logic [AW-1:0] m1_addr;
    logic          m1_we;
    logic [DW-1:0] m1_wdata;
    logic          m1_gnt;
    logic          m1_rvalid;
    logic [DW-1:0] m1_rdata;

    logic          s_req;
    logic [AW-1:0] s_addr;
    logic          s_we;
    logic [DW-1:0] s_wdata;
    logic          s_ready;
    logic [DW-1:0] s_rdata;

    logic          hold_flag_o;

    modport master (
        output m0_req, m0_addr, m0_we, m0_wdata,
        output m1_req, m1_addr, m1_we, m1_wdata,
        output s_ready, s_rdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  s_req, s_addr, s_we, s_wdata,
        input  hold_flag_o
    );

    modport slave (
        input  m0_req, m0_addr, m0_we, m0_wdata,
        input  m1_req, m1_addr, m1_we, m1_wdata,
        input  s_ready, s_rdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output s_req, s_addr, s_we, s_wdata,
        output hold_flag_o
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one single-port memory between fetch (m0) and load/store (m1).
// m1 has priority; a saturating denial counter forces one m0 accept after MAX_WAIT losses.
module mem_bus_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4
) (
    input logic              clk,
    input logic              rst,
    mem_bus_arbiter_if.slave bus
);
    localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

    logic [3:0] starve_cnt;
    logic       resp_valid;
    logic       resp_owner;
    logic       force_m0;
    logic       sel_m0;
    logic       accept;

    always_comb begin
        force_m0 = (MAX_W != 4'd0) && (starve_cnt == MAX_W);
        sel_m0   = bus.m0_req && (!bus.m1_req || force_m0);
        // rst is folded in so grants are quiet for the whole reset window
        accept   = rst && bus.s_ready && (bus.m0_req || bus.m1_req);
    end

    always_comb begin
        bus.m0_gnt  = accept && sel_m0;
        bus.m1_gnt  = accept && !sel_m0;
        bus.s_req   = accept;
        bus.s_addr  = '0;
        bus.s_we    = 1'b0;
        bus.s_wdata = '0;
        if (accept && sel_m0) begin
            bus.s_addr  = bus.m0_addr;
            bus.s_we    = bus.m0_we;
            bus.s_wdata = bus.m0_wdata;
        end else if (accept) begin
            bus.s_addr  = bus.m1_addr;
            bus.s_we    = bus.m1_we;
            bus.s_wdata = bus.m1_wdata;
        end
        bus.hold_flag_o = bus.m0_req && !bus.m0_gnt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= 4'd0;
        end else if (bus.m0_gnt || !bus.m0_req) begin
            starve_cnt <= 4'd0;
        end else if (bus.m1_gnt && (starve_cnt != MAX_W)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_valid <= 1'b0;
            resp_owner <= 1'b0;
        end else begin
            resp_valid <= accept;
            if (accept) begin
                resp_owner <= !sel_m0;
            end
        end
    end

    always_comb begin
        bus.m0_rvalid = resp_valid && !resp_owner;
        bus.m1_rvalid = resp_valid && resp_owner;
        bus.m0_rdata  = bus.m0_rvalid ? bus.s_rdata : '0;
        bus.m1_rdata  = bus.m1_rvalid ? bus.s_rdata : '0;
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized and directed bench for mem_bus_arbiter with a scoreboard per build
// (MAX_WAIT=4 and MAX_WAIT=0), both fed the same master stimulus.
module tb_mem_bus_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          m0_req, m0_we, m1_req, m1_we, s_ready;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic [DW-1:0] srd_a, srd_b;

    mem_bus_arbiter_if #(.AW(AW), .DW(DW)) ifa ();
    mem_bus_arbiter_if #(.AW(AW), .DW(DW)) ifb ();

    mem_bus_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(4)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    mem_bus_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    assign ifa.m0_req = m0_req;   assign ifb.m0_req = m0_req;
    assign ifa.m0_addr = m0_addr; assign ifb.m0_addr = m0_addr;
    assign ifa.m0_we = m0_we;     assign ifb.m0_we = m0_we;
    assign ifa.m0_wdata = m0_wdata; assign ifb.m0_wdata = m0_wdata;
    assign ifa.m1_req = m1_req;   assign ifb.m1_req = m1_req;
    assign ifa.m1_addr = m1_addr; assign ifb.m1_addr = m1_addr;
    assign ifa.m1_we = m1_we;     assign ifb.m1_we = m1_we;
    assign ifa.m1_wdata = m1_wdata; assign ifb.m1_wdata = m1_wdata;
    assign ifa.s_ready = s_ready; assign ifb.s_ready = s_ready;
    assign ifa.s_rdata = srd_a;   assign ifb.s_rdata = srd_b;

    // DUT outputs gathered into arrays indexed by build (0: MAX_WAIT=4, 1: MAX_WAIT=0)
    logic        g0[2], g1[2], sq[2], sw[2], hf[2], rv0[2], rv1[2];
    logic [31:0] sa[2], sd[2], rd0[2], rd1[2];
    always_comb begin
        g0[0] = ifa.m0_gnt;  g0[1] = ifb.m0_gnt;
        g1[0] = ifa.m1_gnt;  g1[1] = ifb.m1_gnt;
        sq[0] = ifa.s_req;   sq[1] = ifb.s_req;
        sw[0] = ifa.s_we;    sw[1] = ifb.s_we;
        hf[0] = ifa.hold_flag_o; hf[1] = ifb.hold_flag_o;
        rv0[0] = ifa.m0_rvalid; rv0[1] = ifb.m0_rvalid;
        rv1[0] = ifa.m1_rvalid; rv1[1] = ifb.m1_rvalid;
        sa[0] = ifa.s_addr;  sa[1] = ifb.s_addr;
        sd[0] = ifa.s_wdata; sd[1] = ifb.s_wdata;
        rd0[0] = ifa.m0_rdata; rd0[1] = ifb.m0_rdata;
        rd1[0] = ifa.m1_rdata; rd1[1] = ifb.m1_rdata;
    end

    // Slave memory models: 16 words, 1-cycle read latency, reloaded during reset
    logic [31:0] mem_a[16], mem_b[16];
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) begin
                mem_a[i] <= 32'h0F + i;
                mem_b[i] <= 32'h0F + i;
            end
            srd_a <= '0;
            srd_b <= '0;
        end else begin
            srd_a <= $urandom;
            srd_b <= $urandom;
            if (ifa.s_req && ifa.s_ready) begin
                if (ifa.s_we) mem_a[ifa.s_addr[5:2]] <= ifa.s_wdata;
                else srd_a <= mem_a[ifa.s_addr[5:2]];
            end
            if (ifb.s_req && ifb.s_ready) begin
                if (ifb.s_we) mem_b[ifb.s_addr[5:2]] <= ifb.s_wdata;
                else srd_b <= mem_b[ifb.s_addr[5:2]];
            end
        end
    end

    // Reference model state
    typedef struct {
        logic        own;
        logic        wr;
        logic [31:0] data;
    } exp_t;
    exp_t        qa[$], qb[$];
    int          starve[2];
    int          lim[2];
    logic [31:0] refm[2][16];

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s build%0d t=%0t: got %h expected %h", nm, d, $time, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input int d, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s build%0d t=%0t: got %b expected %b", nm, d, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            starve[d] = 0;
            for (int i = 0; i < 16; i++) refm[d][i] = 32'h0F + i;
        end
        qa.delete();
        qb.delete();
    endtask

    task automatic drive(input logic r0, input logic [31:0] a0, input logic w0, input logic [31:0] d0,
                         input logic r1, input logic [31:0] a1, input logic w1, input logic [31:0] d1,
                         input logic rdy);
        @(negedge clk);
        m0_req = r0; m0_addr = a0; m0_we = w0; m0_wdata = d0;
        m1_req = r1; m1_addr = a1; m1_we = w1; m1_wdata = d1;
        s_ready = rdy;
        #2;
        for (int d = 0; d < 2; d++) begin
            logic        acc, pick0, ew;
            logic [31:0] ea, ed;
            exp_t        e;
            acc   = rst && rdy && (r0 || r1);
            // m0 wins when m1 is idle, or when it has already lost lim[d] times in a row
            pick0 = r0 && (!r1 || (lim[d] != 0 && starve[d] == lim[d]));
            ea = !acc ? 32'h0 : (pick0 ? a0 : a1);
            ew = !acc ? 1'b0  : (pick0 ? w0 : w1);
            ed = !acc ? 32'h0 : (pick0 ? d0 : d1);
            chk1("m0_gnt", d, g0[d], acc && pick0);
            chk1("m1_gnt", d, g1[d], acc && !pick0);
            chk1("s_req", d, sq[d], acc);
            chk1("hold_flag_o", d, hf[d], r0 && !(acc && pick0));
            chk("s_addr", d, sa[d], ea);
            chk1("s_we", d, sw[d], ew);
            chk("s_wdata", d, sd[d], ed);
            if (acc) begin
                e.own  = !pick0;
                e.wr   = ew;
                e.data = refm[d][ea[5:2]];
                if (ew) refm[d][ea[5:2]] = ed;
                if (d == 0) qa.push_back(e);
                else qb.push_back(e);
            end
            if (rst) begin
                if ((acc && pick0) || !r0) starve[d] = 0;
                else if (acc) starve[d] = (starve[d] < lim[d]) ? starve[d] + 1 : lim[d];
            end
        end
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    // Monitor: every cycle each build either presents exactly the next queued response or nothing
    initial begin
        forever begin
            @(posedge clk);
            #2;
            for (int d = 0; d < 2; d++) begin
                exp_t e;
                bit   have;
                have = (d == 0) ? (qa.size() > 0) : (qb.size() > 0);
                if (have) begin
                    e = (d == 0) ? qa.pop_front() : qb.pop_front();
                    chk1("m0_rvalid", d, rv0[d], !e.own);
                    chk1("m1_rvalid", d, rv1[d], e.own);
                    if (e.own) begin
                        chk("m0_rdata_idle", d, rd0[d], 32'h0);
                        if (!e.wr) chk("m1_rdata", d, rd1[d], e.data);
                    end else begin
                        chk("m1_rdata_idle", d, rd1[d], 32'h0);
                        if (!e.wr) chk("m0_rdata", d, rd0[d], e.data);
                    end
                end else begin
                    chk1("m0_rvalid_idle", d, rv0[d], 1'b0);
                    chk1("m1_rvalid_idle", d, rv1[d], 1'b0);
                    chk("m0_rdata_idle", d, rd0[d], 32'h0);
                    chk("m1_rdata_idle", d, rd1[d], 32'h0);
                end
            end
        end
    end

    initial begin
        lim[0] = 4;
        lim[1] = 0;
        rst = 1'b0;
        m0_req = 0; m0_addr = 0; m0_we = 0; m0_wdata = 0;
        m1_req = 0; m1_addr = 0; m1_we = 0; m1_wdata = 0;
        s_ready = 0;
        model_reset();

        // reset state, with and without a pending fetch
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        drive(1, 32'h10, 0, 0, 1, 32'h20, 0, 0, 1);
        @(posedge clk); #1 rst = 1'b1;

        // single fetch read of 0x10
        drive(1, 32'h10, 0, 0, 0, 0, 0, 0, 1);
        idle();

        // contention: m0 held, m1 new address each cycle
        for (int k = 0; k < 6; k++) drive(1, 32'h24, 0, 0, 1, 32'h40 + 4 * k, 0, 0, 1);
        idle();

        // m1 write then m0 read-back of the same word
        drive(0, 0, 0, 0, 1, 32'h80, 1, 32'hDEADBEEF, 1);
        drive(1, 32'h80, 0, 0, 0, 0, 0, 0, 1);
        idle();

        // counter climbs to 3, freezes over a stalled slave, then m1 then m0
        for (int k = 0; k < 3; k++) drive(1, 32'h8, 0, 0, 1, 32'h30 + 4 * k, 0, 0, 1);
        for (int k = 0; k < 3; k++) drive(1, 32'h8, 0, 0, 1, 32'h3C, 0, 0, 0);
        drive(1, 32'h8, 0, 0, 1, 32'h3C, 0, 0, 1);
        drive(1, 32'h8, 0, 0, 1, 32'h1C, 0, 0, 1);
        idle();

        // reset lands while an m1 response is in flight
        drive(0, 0, 0, 0, 1, 32'h44, 1, 32'h12345678, 1);
        @(posedge clk); #1 rst = 1'b0;
        model_reset();
        drive(1, 32'h14, 0, 0, 0, 0, 0, 0, 1);
        @(posedge clk); #1 rst = 1'b1;
        drive(1, 32'h14, 0, 0, 0, 0, 0, 0, 1);
        drive(1, 32'h44, 0, 0, 0, 0, 0, 0, 1);

        // sustained contention: strict priority on the MAX_WAIT=0 build
        for (int k = 0; k < 10; k++) drive(1, 32'h4, 0, 0, 1, 32'h8 + 4 * k, 0, 0, 1);
        idle();

        for (int k = 0; k < 400; k++) begin
            drive($urandom_range(0, 3) != 0, {$urandom} & 32'hFFFF_FFFC, $urandom_range(0, 7) == 0, $urandom,
                  $urandom_range(0, 2) != 0, {$urandom} & 32'hFFFF_FFFC, $urandom_range(0, 3) == 0, $urandom,
                  $urandom_range(0, 3) != 0);
        end
        idle();
        idle();
        @(posedge clk); #3;
        chk("queue_a_drained", 0, qa.size(), 0);
        chk("queue_b_drained", 1, qb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
